serial_sub_add: RTL
===================

Name: serial_sub_add

Overview:
- Parametrised, multi-cycle adder/subtractor: successor to the fixed 8-bit ripple subtractor/adder.
- Processes DIGIT bits per clock over WIDTH-bit operands.
- Uses a START/BUSY/DONE handshake and registered results, trading latency for area in wide datapaths.
- Sits between operand registers and the result bus in the lab datapath.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be an integer multiple of DIGIT.
- DIGIT, 2: bits processed per clock, 1..WIDTH. N = WIDTH/DIGIT cycles per operation.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- START  input  1  request; sampled on CLK rise, accepted only in IDLE or DONE state
- SUB_ADD  input  1  0 = add (A+B+B_CIN), 1 = subtract (A-B-B_CIN); captured at accept
- B_CIN  input  1  carry-in (add) or borrow-in (subtract); captured at accept
- A  input  WIDTH  minuend/addend; captured at accept
- B  input  WIDTH  subtrahend/addend; captured at accept
- BUSY  output  1  high while the operation is in progress (RUN state)
- DONE  output  1  one-cycle pulse; D_S/B_COUT valid from this cycle
- D_S  output  WIDTH  registered difference/sum; held until the next completion
- B_COUT  output  1  registered carry-out (add) or borrow-out (subtract)

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: BUSY=0, DONE=0, D_S=0, B_COUT=0; internal counter, operand shift registers and running carry all cleared.
- RESET is asynchronous; asserted mid-RUN, it aborts the operation, returns to IDLE and produces no DONE.
- IDLE: START=1 captures A, B, SUB_ADD, B_CIN, loads the running carry/borrow with B_CIN, clears the digit counter and goes to RUN.
- RUN: each edge processes the least-significant DIGIT bits of the shift registers.
  - Per-bit sum/difference = x^y^c.
  - Add carry = xy | yc | xc.
  - Subtract borrow = ~x&y | y&c | ~x&c.
  - Result digits shift into the result register from the MSB end; the operand registers shift right by DIGIT.
  - Counter increments per digit.
- After the Nth digit edge: D_S and B_COUT are loaded from the completed result and the final carry/borrow; state goes to DONE.
- DONE: DONE=1 and BUSY=0 for exactly one cycle.
  - START=1 in this cycle is accepted back-to-back (goes to RUN); otherwise the state goes to IDLE.
- Latency: START accepted at edge k -> BUSY=1 for cycles k+1..k+N, DONE=1 in cycle k+N+1.
  - Throughput: one operation per N+1 cycles.
- START while in RUN is ignored; operand changes during RUN have no effect.
- D_S/B_COUT change only at completion; they hold their values through IDLE and subsequent RUN.
- Wrap-around: the result is modulo 2^WIDTH; the overflow/borrow appears only on B_COUT.
- DIGIT=WIDTH: N=1, single-cycle RUN.

Optional Feature:
- Macro: SERIAL_SUB_ADD_SAT_EN.
- Defined: unsigned saturation at completion.
  - Add with final carry=1 -> D_S all ones.
  - Subtract with final borrow=1 -> D_S all zeros.
  - B_COUT still reports the raw carry/borrow.
- Undefined: wrap-around result as in Behaviour; no saturation logic synthesised.

Test Plan:
- WIDTH=8, DIGIT=2: add A=0x3C, B=0x55, B_CIN=0 -> BUSY high 4 cycles, DONE pulse in cycle 5, D_S=0x91, B_COUT=0.
- Add A=0xFF, B=0x01, B_CIN=1 -> D_S=0x01, B_COUT=1. With SERIAL_SUB_ADD_SAT_EN -> D_S=0xFF, B_COUT=1.
- Subtract A=0x10, B=0x20, B_CIN=0 -> D_S=0xF0, B_COUT=1. With SERIAL_SUB_ADD_SAT_EN -> D_S=0x00.
- Subtract A=0x80, B=0x01, B_CIN=1 -> D_S=0x7E, B_COUT=0. Then START held high in the DONE cycle with add 0x01+0x01 -> next DONE 5 cycles later, D_S=0x02.
- Start an add, change A/B and pulse START mid-RUN -> ignored, original result delivered. Then RESET asserted at RUN cycle 2 -> BUSY, DONE, D_S, B_COUT = 0 immediately, no DONE pulse, next START operates normally.
- Sweep DIGIT=1, 4, 8 with WIDTH=8 over 1000 random operations -> D_S/B_COUT match a reference model; latency N+1 = 9, 3, 2 cycles.

Source files
------------

// File: rtl/serial_sub_add_if.sv
// rtl/serial_sub_add_if.sv - handshake and operand/result bundle for serial_sub_add
//
// Purpose: groups the request side (START, SUB_ADD, B_CIN, A, B) and the
// response side (BUSY, DONE, D_S, B_COUT) of the serial adder/subtractor.
//
// Signals:
//   START    request, sampled on the clock rise, accepted in IDLE or DONE
//   SUB_ADD  0 = add (A+B+B_CIN), 1 = subtract (A-B-B_CIN)
//   B_CIN    carry-in (add) or borrow-in (subtract)
//   A, B     WIDTH-bit operands
//   BUSY     high while an operation is running
//   DONE     one-cycle completion pulse
//   D_S      registered sum/difference, held until the next completion
//   B_COUT   registered carry-out (add) or borrow-out (subtract)
//
// Modports: master drives requests (operand side), slave is the arithmetic unit.

interface serial_sub_add_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             SUB_ADD;
  logic             B_CIN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] D_S;
  logic             B_COUT;

  modport master (
    output START,
    output SUB_ADD,
    output B_CIN,
    output A,
    output B,
    input  BUSY,
    input  DONE,
    input  D_S,
    input  B_COUT
  );

  modport slave (
    input  START,
    input  SUB_ADD,
    input  B_CIN,
    input  A,
    input  B,
    output BUSY,
    output DONE,
    output D_S,
    output B_COUT
  );
endinterface

// File: rtl/serial_sub_add.sv
// rtl/serial_sub_add.sv - digit-serial WIDTH-bit adder/subtractor with START/BUSY/DONE handshake
//
// Purpose: adds or subtracts two WIDTH-bit operands DIGIT bits per clock,
// taking N = WIDTH/DIGIT RUN cycles followed by a one-cycle DONE state.
// Results are registered and held until the next completion.
//
// Parameters:
//   WIDTH  operand/result width, integer multiple of DIGIT
//   DIGIT  bits processed per clock, 1..WIDTH
//
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous, active-high reset (aborts a running operation)
//   bus    serial_sub_add_if.slave: START/SUB_ADD/B_CIN/A/B in,
//          BUSY/DONE/D_S/B_COUT out
//
// Optional feature: define SERIAL_SUB_ADD_SAT_EN for unsigned saturation of
// D_S at completion (add overflow -> all ones, subtract underflow -> zero).
// B_COUT always reports the raw carry/borrow.

module serial_sub_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  serial_sub_add_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_s_q, d_s_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             b_cout_q, b_cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_carry;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] final_ds;
  logic             accept;
  logic             last_digit;

  // Ripple through the DIGIT low bits of the operand shift registers,
  // starting from the running carry/borrow.
  always_comb begin
    logic c;
    c       = carry_q;
    dig_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
      if (sub_q) begin
        c = (~a_q[i] & b_q[i]) | (b_q[i] & c) | (~a_q[i] & c);
      end else begin
        c = (a_q[i] & b_q[i]) | (b_q[i] & c) | (a_q[i] & c);
      end
    end
    dig_carry = c;
  end

  // New digits enter at the MSB end; after N digits the first digit has
  // reached bit 0, so the register holds the result in natural order.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

`ifdef SERIAL_SUB_ADD_SAT_EN
  assign final_ds = dig_carry ? (sub_q ? '0 : '1) : res_shift;
`else
  assign final_ds = res_shift;
`endif

  assign accept     = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.START;
  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_s_d    = d_s_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    b_cout_d = b_cout_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sub_d   = bus.SUB_ADD;
          carry_d = bus.B_CIN;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // START and operand inputs are deliberately not looked at here.
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dig_carry;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          d_s_d    = final_ds;
          b_cout_d = dig_carry;
          state_d  = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_s_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      b_cout_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_s_q    <= d_s_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      b_cout_q <= b_cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.BUSY   = (state_q == S_RUN);
  assign bus.DONE   = (state_q == S_DONE);
  assign bus.D_S    = d_s_q;
  assign bus.B_COUT = b_cout_q;

endmodule
